// File: rtl/fetch_stage_if.sv
// Instruction-memory request bus between the fetch stage and imem.
// Fetch side is master; memory answers with ready/rdata.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// MIPS IF stage: PC, imem req/ready fetch, IF/ID register.
// FETCH/DISCARD/HOLD FSM with a one-entry hold buffer.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [31:0]          redirect_pc,
  fetch_stage_if.master        imem,
  output logic [31:0]          ifid_instr,
  output logic [5:0]           ifid_opcode,
  output logic [31:0]          ifid_pc4,
  output logic                 ifid_valid
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_DISCARD,
    S_HOLD
  } state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } ifid_t;

  localparam ifid_t BUBBLE = '{instr: NOP, pc4: 32'h0, valid: 1'b0};

  state_t      r_state;
  state_t      w_state_nxt;
  ifid_t       r_ifid;
  ifid_t       w_ifid_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] r_buf;
  logic [31:0] w_buf_nxt;
  logic [31:0] r_buf_pc4;
  logic [31:0] w_buf_pc4_nxt;
  logic [31:0] r_pend_pc;
  logic [31:0] w_pend_nxt;
  logic [31:0] w_pc4;
  logic        w_ready;

  assign w_pc4   = r_pc + 32'd4;
  assign w_ready = imem.imem_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_FETCH: begin
        if (redirect) begin
          w_state_nxt = w_ready ? S_FETCH : S_DISCARD;
        end else if (w_ready && stall) begin
          w_state_nxt = S_HOLD;
        end
      end
      S_DISCARD: begin
        if (w_ready) begin
          w_state_nxt = S_FETCH;
        end
      end
      S_HOLD: begin
        if (redirect || !stall) begin
          w_state_nxt = S_FETCH;
        end
      end
      default: w_state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    w_pc_nxt      = r_pc;
    w_ifid_nxt    = r_ifid;
    w_buf_nxt     = r_buf;
    w_buf_pc4_nxt = r_buf_pc4;
    w_pend_nxt    = r_pend_pc;
    unique case (r_state)
      S_FETCH: begin
        if (redirect) begin
          w_ifid_nxt = BUBBLE;
          if (w_ready) begin
            w_pc_nxt = redirect_pc;
          end else begin
            w_pend_nxt = redirect_pc;
          end
        end else if (w_ready) begin
          w_pc_nxt = w_pc4;
          if (stall) begin
            w_buf_nxt     = imem.imem_rdata;
            w_buf_pc4_nxt = w_pc4;
          end else begin
            w_ifid_nxt = '{instr: imem.imem_rdata,
                           pc4: w_pc4, valid: 1'b1};
          end
        end else if (!stall) begin
          w_ifid_nxt = BUBBLE;
        end
      end
      S_DISCARD: begin
        // Flushed stream: stall is irrelevant, newest redirect wins.
        w_ifid_nxt = BUBBLE;
        if (redirect) begin
          w_pend_nxt = redirect_pc;
        end
        if (w_ready) begin
          w_pc_nxt = redirect ? redirect_pc : r_pend_pc;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          w_pc_nxt   = redirect_pc;
          w_ifid_nxt = BUBBLE;
        end else if (!stall) begin
          w_ifid_nxt = '{instr: r_buf,
                         pc4: r_buf_pc4, valid: 1'b1};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc      <= RESET_PC;
      r_ifid    <= BUBBLE;
      r_buf     <= 32'h0;
      r_buf_pc4 <= 32'h0;
      r_pend_pc <= 32'h0;
    end else begin
      r_pc      <= w_pc_nxt;
      r_ifid    <= w_ifid_nxt;
      r_buf     <= w_buf_nxt;
      r_buf_pc4 <= w_buf_pc4_nxt;
      r_pend_pc <= w_pend_nxt;
    end
  end

  // Address is the PC register, so it is stable across wait states.
  assign imem.imem_req  = !rst && (r_state != S_HOLD);
  assign imem.imem_addr = r_pc;
  assign ifid_instr     = r_ifid.instr;
  assign ifid_opcode    = r_ifid.instr[31:26];
  assign ifid_pc4       = r_ifid.pc4;
  assign ifid_valid     = r_ifid.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, corner sequences,
// then random stimulus against a queue-based reference model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] ifid_instr;
  logic [5:0]  ifid_opcode;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;

  int n_chk  = 0;
  int n_fail = 0;

  fetch_stage_if bus();

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (bus.master),
    .ifid_instr  (ifid_instr),
    .ifid_opcode (ifid_opcode),
    .ifid_pc4    (ifid_pc4),
    .ifid_valid  (ifid_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A00_C3A5;
  endfunction

  assign bus.imem_rdata = word(bus.imem_addr);

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic chk_ifid(input string tag, input logic v,
                          input logic [31:0] pc4);
    logic [31:0] ei;
    ei = v ? word(pc4 - 32'd4) : 32'h0;
    chk({tag, ".valid"}, {31'h0, ifid_valid}, {31'h0, v});
    chk({tag, ".pc4"}, ifid_pc4, v ? pc4 : 32'h0);
    chk({tag, ".instr"}, ifid_instr, ei);
    chk({tag, ".opcode"}, {26'h0, ifid_opcode}, {26'h0, ei[31:26]});
  endtask

  task automatic chk_bus(input string tag, input logic req,
                         input logic [31:0] addr);
    chk({tag, ".req"}, {31'h0, bus.imem_req}, {31'h0, req});
    chk({tag, ".addr"}, bus.imem_addr, addr);
  endtask

  task automatic drive(input logic rdy, input logic stl,
                       input logic rdr, input logic [31:0] rpc);
    bus.imem_ready = rdy;
    stall          = stl;
    redirect       = rdr;
    redirect_pc    = rpc;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    #1;
    chk_bus("rst", 1'b0, 32'h0);
    chk_ifid("rst", 1'b0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_bus("rel", 1'b1, 32'h0);
  endtask

  typedef struct {
    logic        rdy;
    logic        stl;
    logic        rdr;
    logic [31:0] rpc;
    logic        ereq;
    logic [31:0] eaddr;
    logic        ev;
    logic [31:0] epc4;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mk(logic rdy, logic stl, logic rdr,
                              logic [31:0] rpc, logic ereq,
                              logic [31:0] eaddr, logic ev,
                              logic [31:0] epc4);
    vec_t v;
    v.rdy = rdy; v.stl = stl; v.rdr = rdr; v.rpc = rpc;
    v.ereq = ereq; v.eaddr = eaddr; v.ev = ev; v.epc4 = epc4;
    return v;
  endfunction

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } ent_t;

  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  logic        m_valid;
  ent_t        hold_q[$];
  logic [31:0] disc_q[$];

  task automatic m_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    hold_q.delete();
    disc_q.delete();
  endtask

  task automatic m_bubble();
    m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
  endtask

  task automatic m_step(input logic rdy, input logic stl,
                        input logic rdr, input logic [31:0] rpc);
    ent_t e;
    if (hold_q.size() > 0) begin
      if (rdr) begin
        hold_q.delete();
        m_pc = rpc;
        m_bubble();
      end else if (!stl) begin
        e = hold_q.pop_front();
        m_instr = e.instr; m_pc4 = e.pc4; m_valid = 1'b1;
      end
    end else if (disc_q.size() > 0) begin
      m_bubble();
      if (rdr) disc_q[0] = rpc;
      if (rdy) begin
        m_pc = disc_q.pop_front();
      end
    end else if (rdr) begin
      m_bubble();
      if (rdy) m_pc = rpc;
      else disc_q.push_back(rpc);
    end else if (rdy) begin
      e.instr = word(m_pc);
      e.pc4   = m_pc + 32'd4;
      m_pc    = e.pc4;
      if (stl) begin
        hold_q.push_back(e);
      end else begin
        m_instr = e.instr; m_pc4 = e.pc4; m_valid = 1'b1;
      end
    end else if (!stl) begin
      m_bubble();
    end
  endtask

  task automatic m_check();
    chk("rnd.req", {31'h0, bus.imem_req},
        {31'h0, hold_q.size() == 0});
    chk("rnd.addr", bus.imem_addr, m_pc);
    chk("rnd.valid", {31'h0, ifid_valid}, {31'h0, m_valid});
    chk("rnd.pc4", ifid_pc4, m_pc4);
    chk("rnd.instr", ifid_instr, m_instr);
    chk("rnd.opcode", {26'h0, ifid_opcode}, {26'h0, m_instr[31:26]});
  endtask

  initial begin
    tbl[0]  = mk(1, 0, 0, 0,        1, 32'h04,  1, 32'h04);
    tbl[1]  = mk(1, 0, 0, 0,        1, 32'h08,  1, 32'h08);
    tbl[2]  = mk(0, 0, 0, 0,        1, 32'h08,  0, 0);
    tbl[3]  = mk(0, 0, 0, 0,        1, 32'h08,  0, 0);
    tbl[4]  = mk(1, 0, 0, 0,        1, 32'h0C,  1, 32'h0C);
    tbl[5]  = mk(1, 0, 0, 0,        1, 32'h10,  1, 32'h10);
    tbl[6]  = mk(1, 1, 0, 0,        0, 32'h14,  1, 32'h10);
    tbl[7]  = mk(1, 1, 0, 0,        0, 32'h14,  1, 32'h10);
    tbl[8]  = mk(1, 1, 0, 0,        0, 32'h14,  1, 32'h10);
    tbl[9]  = mk(1, 0, 0, 0,        1, 32'h14,  1, 32'h14);
    tbl[10] = mk(1, 0, 0, 0,        1, 32'h18,  1, 32'h18);
    tbl[11] = mk(1, 0, 0, 0,        1, 32'h1C,  1, 32'h1C);
    tbl[12] = mk(1, 0, 0, 0,        1, 32'h20,  1, 32'h20);
    tbl[13] = mk(0, 0, 1, 32'h100,  1, 32'h20,  0, 0);
    tbl[14] = mk(0, 1, 0, 0,        1, 32'h20,  0, 0);
    tbl[15] = mk(0, 0, 0, 0,        1, 32'h20,  0, 0);
    tbl[16] = mk(1, 0, 0, 0,        1, 32'h100, 0, 0);
    tbl[17] = mk(1, 0, 0, 0,        1, 32'h104, 1, 32'h104);
    tbl[18] = mk(1, 1, 1, 32'h200,  1, 32'h200, 0, 0);
    tbl[19] = mk(1, 0, 0, 0,        1, 32'h204, 1, 32'h204);

    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].rdy, tbl[i].stl, tbl[i].rdr, tbl[i].rpc);
      @(negedge clk);
      chk_bus($sformatf("vec%0d", i), tbl[i].ereq, tbl[i].eaddr);
      chk_ifid($sformatf("vec%0d", i), tbl[i].ev, tbl[i].epc4);
    end

    // PC wrap at the top of the address space
    drive(1, 0, 1, 32'hFFFF_FFFC);
    @(negedge clk);
    chk_bus("wrap0", 1'b1, 32'hFFFF_FFFC);
    drive(1, 0, 0, 0);
    @(negedge clk);
    chk_bus("wrap1", 1'b1, 32'h0);
    chk_ifid("wrap1", 1'b1, 32'h0);

    // Redirect out of HOLD drops the buffered word
    drive(1, 1, 0, 0);
    @(negedge clk);
    chk_bus("hold", 1'b0, 32'h4);
    drive(0, 1, 1, 32'h300);
    @(negedge clk);
    chk_bus("holdrd", 1'b1, 32'h300);
    chk_ifid("holdrd", 1'b0, 32'h0);

    // Newest redirect wins inside DISCARD
    drive(0, 0, 1, 32'h400);
    @(negedge clk);
    chk_bus("disc0", 1'b1, 32'h300);
    drive(1, 0, 1, 32'h500);
    @(negedge clk);
    chk_bus("disc1", 1'b1, 32'h500);
    chk_ifid("disc1", 1'b0, 32'h0);

    // Async reset mid-DISCARD between edges
    drive(0, 0, 1, 32'h600);
    @(negedge clk);
    chk_bus("disc2", 1'b1, 32'h500);
    #2;
    rst = 1'b1;
    #1;
    chk_bus("arst", 1'b0, 32'h0);
    chk_ifid("arst", 1'b0, 32'h0);
    drive(1, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_bus("arel", 1'b1, 32'h0);
    @(negedge clk);
    chk_bus("arel1", 1'b1, 32'h4);
    chk_ifid("arel1", 1'b1, 32'h4);

    // Random phase against the reference model
    do_reset();
    m_reset();
    for (int i = 0; i < 3000; i++) begin
      logic rdy;
      logic stl;
      logic rdr;
      logic [31:0] rpc;
      rdy = ($urandom_range(0, 9) < 7);
      stl = ($urandom_range(0, 3) == 0);
      rdr = ($urandom_range(0, 9) == 0);
      rpc = {$urandom(), 2'b00} >> 0;
      rpc[1:0] = 2'b00;
      drive(rdy, stl, rdr, rpc);
      m_step(rdy, stl, rdr, rpc);
      @(negedge clk);
      m_check();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the decode-stage control unit. It owns the PC, fetches from instruction memory through a req/ready handshake tolerating wait states, and drives the IF/ID pipeline register whose opcode field feeds the control unit. Stall, branch/jump redirect, and an in-flight-request discard are handled by a 3-state FSM with a one-entry hold buffer.

## Interface
- RESET_PC, 32'h0000_0000, PC value after reset
- NOP, 32'h0000_0000, instruction word inserted as a bubble (opcode 0, sll $0; harmless in decode)
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- stall  in  1  hazard-unit hold of IF/ID (load-use)
- redirect  in  1  taken branch or jump resolved downstream
- redirect_pc  in  32  target for redirect
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address (= PC register)
- imem_ready  in  1  imem_rdata valid, request completes this cycle
- imem_rdata  in  32  fetched instruction word
- ifid_instr  out  32  IF/ID instruction
- ifid_opcode  out  6  ifid_instr[31:26], to control unit opcode input
- ifid_pc4  out  32  address of instruction + 4
- ifid_valid  out  1  IF/ID holds a real instruction

## Operation
- States: FETCH, DISCARD, HOLD. imem_req = 1 in FETCH and DISCARD, 0 in HOLD, forced 0 while rst high.
- Protocol rule: while imem_req=1 and imem_ready=0, imem_addr must not change.
- Priority within a cycle: redirect > stall > normal flow.
- FETCH:
  - ready, no stall, no redirect: IF/ID <= {rdata, pc+4, valid=1}; pc <= pc+4.
  - ready, stall, no redirect: buf <= rdata, buf_pc4 <= pc+4; pc <= pc+4; IF/ID held; -> HOLD.
  - not ready, no redirect: pc held; IF/ID <= bubble if !stall, held if stall.
  - redirect with ready: rdata dropped; pc <= redirect_pc; IF/ID <= bubble; stay FETCH.
  - redirect without ready: pend_pc <= redirect_pc; IF/ID <= bubble; -> DISCARD.
- DISCARD: address held at old pc; IF/ID <= bubble each cycle (stall ignored, stream is flushed). New redirect overwrites pend_pc (newest wins). On ready: rdata dropped, pc <= pend_pc (or redirect_pc if redirect same cycle), -> FETCH.
- HOLD: no request. !stall: IF/ID <= {buf, buf_pc4, 1}; -> FETCH. stall: all held. redirect: buf dropped, pc <= redirect_pc, IF/ID <= bubble, -> FETCH.
- Bubble = {NOP, 32'h0, valid=0}.
- PC arithmetic modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0, no flag.

## Timing
- Reset values (immediate on rst assertion, no clock needed): state FETCH, pc RESET_PC, ifid_instr NOP, ifid_opcode 0, ifid_pc4 0, ifid_valid 0, buf 0, pend_pc 0, imem_req 0.
- First request: first rising edge after rst deasserts finds imem_req=1, imem_addr=RESET_PC.
- Latency: instruction accepted (ready high) at edge N appears on IF/ID after edge N; zero-wait memory gives one instruction per cycle.
- Redirect sampled at edge N: next request at redirect_pc from edge N+1 (FETCH/HOLD) or after the outstanding request completes (DISCARD).
- stall has no effect on PC or request while imem_ready is low in FETCH.
- rst mid-DISCARD/HOLD: pend_pc and buf contents lost; fetch restarts at RESET_PC.

## Test plan
- Reset release, ready tied 1, imem returns addr-derived words -> imem_addr 0,4,8,C on consecutive cycles; ifid_pc4 4,8,C,10 with ifid_valid=1 one cycle after each.
- ready low 2 cycles at addr 0x8 -> imem_addr stays 0x8, imem_req=1, ifid_valid=0 for 2 cycles, then instr@0x8 with pc4 0xC.
- stall high when 0x10 completes, held 3 cycles -> state HOLD, imem_req=0, IF/ID unchanged; stall drop -> IF/ID gets instr@0x10, pc4 0x14, next request 0x14.
- redirect to 0x100 at 0x20 with ready low, ready after 2 more cycles -> addr stays 0x20, its data dropped, ifid_valid=0 throughout, next addr 0x100.
- redirect 0x200 with stall and ready both high -> data dropped, IF/ID bubble, next addr 0x200, FSM in FETCH.
- rst pulse mid-DISCARD between clock edges -> all outputs at reset values before next edge; after release, addr RESET_PC.
